// File: rtl/lock_key_conditioner.sv
// Pushbutton/switch front end for the combination lock: synchronise, debounce, one pulse per press.
// Optional LOCK_KEY_SYNC_EN selects a two-flop synchroniser; otherwise a single input register.
module lock_key_conditioner #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 20
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       key_n,
  input  logic [3:0] sw,
  output logic       enter_pulse,
  output logic [3:0] digit,
  output logic       digit_err,
  output logic       key_held
);

`ifdef LOCK_KEY_SYNC_EN
  localparam int SYNC_STAGES = 2;
`else
  localparam int SYNC_STAGES = 1;
`endif

  localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(DEBOUNCE_CYCLES - 1);
  // With a one-sample debounce the check state still takes one extra cycle (entry count 0).
  localparam logic [CNT_W-1:0] ENTRY_CNT = (DEBOUNCE_CYCLES > 1) ? CNT_W'(1) : '0;

  typedef enum logic [1:0] {
    RELEASED,
    PRESS_CHK,
    PRESSED,
    RELEASE_CHK
  } state_t;

  logic [SYNC_STAGES-1:0]      key_sync_reg;
  logic [SYNC_STAGES-1:0][3:0] sw_sync_reg;
  logic                        k_s;
  logic [3:0]                  sw_s;

  state_t           state_reg;
  logic [CNT_W-1:0] count_reg;
  logic             accept_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      key_sync_reg <= '1;
      sw_sync_reg  <= '0;
    end else begin
      key_sync_reg[0] <= key_n;
      sw_sync_reg[0]  <= sw;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        key_sync_reg[i] <= key_sync_reg[i-1];
        sw_sync_reg[i]  <= sw_sync_reg[i-1];
      end
    end
  end

  assign k_s  = key_sync_reg[SYNC_STAGES-1];
  assign sw_s = sw_sync_reg[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg   <= RELEASED;
      count_reg   <= '0;
      accept_reg  <= 1'b0;
      enter_pulse <= 1'b0;
      digit       <= 4'h0;
      digit_err   <= 1'b0;
      key_held    <= 1'b0;
    end else begin
      // Accepted press is flagged on the transition and emitted one cycle later with the digit.
      accept_reg  <= 1'b0;
      enter_pulse <= accept_reg;
      if (accept_reg) begin
        digit     <= sw_s;
        digit_err <= (sw_s > 4'd9);
      end

      case (state_reg)
        RELEASED: begin
          key_held <= 1'b0;
          if (!k_s) begin
            state_reg <= PRESS_CHK;
            count_reg <= ENTRY_CNT;
          end else begin
            count_reg <= '0;
          end
        end
        PRESS_CHK: begin
          if (k_s) begin
            state_reg <= RELEASED;
            count_reg <= '0;
            key_held  <= 1'b0;
          end else if (count_reg == LAST_CNT) begin
            state_reg  <= PRESSED;
            count_reg  <= '0;
            accept_reg <= 1'b1;
            key_held   <= 1'b1;
          end else begin
            count_reg <= count_reg + CNT_W'(1);
            key_held  <= 1'b0;
          end
        end
        PRESSED: begin
          key_held <= 1'b1;
          if (k_s) begin
            state_reg <= RELEASE_CHK;
            count_reg <= ENTRY_CNT;
          end
        end
        RELEASE_CHK: begin
          if (!k_s) begin
            state_reg <= PRESSED;
            count_reg <= '0;
            key_held  <= 1'b1;
          end else if (count_reg == LAST_CNT) begin
            state_reg <= RELEASED;
            count_reg <= '0;
            key_held  <= 1'b0;
          end else begin
            count_reg <= count_reg + CNT_W'(1);
            key_held  <= 1'b1;
          end
        end
        default: begin
          state_reg <= RELEASED;
          count_reg <= '0;
          key_held  <= 1'b0;
        end
      endcase
    end
  end

endmodule
